ysyx_22040365_ifu: RTL
======================

Name: ysyx_22040365_ifu

Overview:
- Instruction fetch unit: owns the PC and issues 32-bit instruction fetches to instruction memory over a valid/ready request plus valid response channel.
- Delivers {inst, pc} to the decode stage over a valid/ready handshake.
- Accepts redirects (branch/jump) from execute.
- Sits between the I-memory port and the decoder. It is the producer side of the decoder's instruction input.

Parameters:
- XLEN, 64, width of pc and addresses.
- RESET_PC, 64'h8000_0000, PC loaded on reset.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset. One clock; reset sampled on the rising edge of clk.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  XLEN  fetch address (= pc).
- imem_resp_valid  input  1  response data valid (one pulse per accepted request).
- imem_resp_data  input  32  fetched instruction word.
- inst_valid  output  1  instruction available to decode.
- inst_ready  input  1  decode consumes instruction.
- inst  output  32  instruction word to decode.
- inst_pc  output  XLEN  address of inst.
- redirect_valid  input  1  next-PC override from execute.
- redirect_pc  input  XLEN  override target; bits [1:0] ignored (forced 0).
- fetch_busy  output  1  high while a request is outstanding (state WAIT).

Behaviour:
- FSM states (encoded in defines): S_REQ, S_WAIT, S_HOLD.
- Registers: pc, state, inst_q, drop.
- Reset (rst_n=0 at clk edge):
  - state=S_REQ, pc=RESET_PC, inst_q=0, drop=0.
  - While rst_n=0: imem_req_valid=0, inst_valid=0, fetch_busy=0 (combinationally gated).
  - inst=0, inst_pc=RESET_PC.
  - Reset mid-operation abandons any outstanding request. A later stray response is ignored, because state is S_REQ and S_REQ ignores imem_resp_valid.
- S_REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - redirect_valid & !imem_req_ready: pc<=redirect_pc, stay S_REQ.
  - imem_req_ready & !redirect_valid: ->S_WAIT, drop<=0.
  - imem_req_ready & redirect_valid: request for old pc is accepted. ->S_WAIT, drop<=1, pc<=redirect_pc.
- S_WAIT:
  - fetch_busy=1.
  - imem_resp_valid & (drop | redirect_valid): discard data, ->S_REQ, drop<=0. If redirect_valid, pc<=redirect_pc.
  - imem_resp_valid & !drop & !redirect_valid: inst_q<=imem_resp_data, ->S_HOLD.
  - redirect_valid & !imem_resp_valid: pc<=redirect_pc, drop<=1, stay S_WAIT.
- S_HOLD:
  - inst_valid = (state==S_HOLD) & !redirect_valid, i.e. redirect suppresses valid in the same cycle, so no transfer occurs.
  - inst=inst_q, inst_pc=pc.
  - inst_valid & inst_ready: pc<=pc+4 (XLEN wrap-around allowed), ->S_REQ.
  - redirect_valid: pc<=redirect_pc, ->S_REQ; inst_q discarded.
  - Otherwise hold; inst and inst_pc are stable while valid & !ready.
- Timing:
  - Request accepted in cycle n; response earliest in n+1; inst_valid earliest in n+2.
  - Next request earliest in the cycle after the decode handshake.
  - Peak throughput is 1 instruction per 3 cycles.
- Priority: reset > redirect > handshakes.
- At most one outstanding request; imem_req_valid=0 in S_WAIT and S_HOLD.
- imem_req_valid, once asserted, stays high until accepted, unless a redirect arrives; the address then changes to the new pc.

Decomposition:
- ysyx_22040365_defines.v: RESET_PC value, state encodings (S_REQ/S_WAIT/S_HOLD), instruction width 32.
- One natural sub-module, ysyx_22040365_pc_reg: pc register with reset, redirect and +4 select.
- The FSM stays in the top module.

Test Plan:
- Reset then streaming: rst_n low 2 cycles, memory always ready, 1-cycle response returning 32'h00100093 / 32'h00200113, inst_ready=1. First request addr 0x80000000; inst_valid with inst_pc 0x80000000 then 0x80000004, 3 cycles apart.
- Decode backpressure: inst_ready=0 for 5 cycles in S_HOLD. inst and inst_pc stable, no new request. inst_ready=1 gives next req_addr 0x80000004.
- Redirect in S_WAIT: redirect_pc=0x80000100 before response arrives. Response is dropped, no inst_valid. Next request addr 0x80000100.
- Redirect together with req accept: same cycle as imem_req_ready, redirect_pc=0x80000200. Response for 0x80000000 is discarded. Next request 0x80000200, inst_pc 0x80000200.
- Redirect in S_HOLD with inst_ready=1 the same cycle: inst_valid=0 that cycle, no transfer. Next request is redirect_pc 0x80000040 with bits [1:0] forced to 0 (redirect_pc=0x80000043 → 0x80000040).
- Reset mid-fetch: rst_n=0 while in S_WAIT, then a stray resp_valid. Outputs return to reset values, the stray response is ignored, and fetch restarts at 0x80000000.

Source files
------------

// File: rtl/ysyx_22040365_ifu_pkg.sv
// Shared constants for the instruction fetch unit: reset PC,
// instruction width and FSM state encodings.
package ysyx_22040365_ifu_pkg;

    localparam int          ILEN       = 32;
    localparam logic [63:0] RESET_PC_D = 64'h8000_0000;

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

endpackage

// File: rtl/ysyx_22040365_ifu_if.sv
// Fetch-unit bus: I-memory request/response, decode handshake,
// execute redirect and busy status.
interface ysyx_22040365_ifu_if #(parameter int XLEN = 64);

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [31:0]     imem_resp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            fetch_busy;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        output inst_valid, inst, inst_pc, fetch_busy,
        input  inst_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        input  inst_valid, inst, inst_pc, fetch_busy,
        output inst_ready, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/ysyx_22040365_pc_reg.sv
// Program counter: reset value, redirect load (word aligned)
// and sequential +4 advance.
module ysyx_22040365_pc_reg #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_redir,
    input  logic [XLEN-1:0] i_redir_pc,
    input  logic            i_inc,
    output logic [XLEN-1:0] o_pc
);

    logic [XLEN-1:0] r_pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (i_redir) begin
            r_pc <= {i_redir_pc[XLEN-1:2], 2'b00};
        end else if (i_inc) begin
            r_pc <= r_pc + XLEN'(4);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/ysyx_22040365_ifu.sv
// Instruction fetch unit: one outstanding I-memory request,
// delivers {inst, pc} to decode, honours execute redirects.
module ysyx_22040365_ifu
    import ysyx_22040365_ifu_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_D[XLEN-1:0]
) (
    input logic                    clk,
    input logic                    rst_n,
    ysyx_22040365_ifu_if.master    bus
);

    logic [1:0]      r_state;
    logic            r_drop;
    logic [ILEN-1:0] r_inst_q;
    logic [XLEN-1:0] w_pc;
    logic            w_inst_valid;
    logic            w_inc;

    ysyx_22040365_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_redir    (bus.redirect_valid),
        .i_redir_pc (bus.redirect_pc),
        .i_inc      (w_inc),
        .o_pc       (w_pc)
    );

    // A redirect in HOLD kills the offer so no transfer can race it
    assign w_inst_valid = rst_n & (r_state == S_HOLD) & ~bus.redirect_valid;
    assign w_inc        = w_inst_valid & bus.inst_ready;

    assign bus.imem_req_valid = rst_n & (r_state == S_REQ);
    assign bus.imem_req_addr  = w_pc;
    assign bus.fetch_busy     = rst_n & (r_state == S_WAIT);
    assign bus.inst_valid     = w_inst_valid;
    assign bus.inst           = r_inst_q;
    assign bus.inst_pc        = w_pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_REQ;
            r_drop   <= 1'b0;
            r_inst_q <= '0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (bus.imem_req_ready) begin
                        r_state <= S_WAIT;
                        r_drop  <= bus.redirect_valid;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_resp_valid) begin
                        if (r_drop | bus.redirect_valid) begin
                            r_state <= S_REQ;
                            r_drop  <= 1'b0;
                        end else begin
                            r_inst_q <= bus.imem_resp_data;
                            r_state  <= S_HOLD;
                        end
                    end else if (bus.redirect_valid) begin
                        r_drop <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (bus.redirect_valid | bus.inst_ready) begin
                        r_state <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_REQ;
                    r_drop  <= 1'b0;
                end
            endcase
        end
    end

endmodule
